// File: rtl/instr_issue_fifo.sv
// instr_issue_fifo: decode->issue decoupling queue, ISSUE_NUM-wide push and 0..ISSUE_NUM pop per cycle.
// Latency: 1 cycle push->out_data; 0 cycles from an empty queue when ISSUE_FIFO_BYPASS_EN is defined.
// Backpressure: push_ready drops when fewer than ISSUE_NUM entries are free; pushes are then ignored.
// Optional feature macro: ISSUE_FIFO_BYPASS_EN (empty-queue bypass from push_data to out_data).

`ifndef ISSUE_NUM
`define ISSUE_NUM 2
`endif

package instr_issue_pkg;
  localparam int ISSUE_NUM_CFG = `ISSUE_NUM;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } pipeline_decode_t;
endpackage

module instr_issue_fifo
  import instr_issue_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ISSUE_NUM = ISSUE_NUM_CFG,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int PW = $clog2(ISSUE_NUM + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  pipeline_decode_t [ISSUE_NUM-1:0] push_data,
  output logic                            push_ready,
  input  logic [PW-1:0]                   pop_num,
  output pipeline_decode_t [ISSUE_NUM-1:0] out_data,
  output logic [CW-1:0]                   count
);

  pipeline_decode_t      mem [DEPTH];
  logic [AW-1:0]         head;
  logic [AW-1:0]         tail;
  logic [PW-1:0]         npush;
  logic [PW-1:0]         pop_lim;
  logic [PW-1:0]         pop_eff;
  logic                  bypass;
  logic [ISSUE_NUM-1:0]  wr_en;

  // Room for a full-width push, judged on the registered count only (this cycle's pop is not credited).
  assign push_ready = (count <= CW'(DEPTH - ISSUE_NUM));

`ifdef ISSUE_FIFO_BYPASS_EN
  assign bypass = (count == '0) && !flush && push_data[0].valid;
`else
  assign bypass = 1'b0;
`endif

  // Accepted push width: the contiguous run of valid slots from slot 0, zero when not ready.
  always_comb begin
    logic run;
    run   = push_ready;
    npush = '0;
    for (int i = 0; i < ISSUE_NUM; i++) begin
      if (run && push_data[i].valid) npush = npush + PW'(1);
      else                           run   = 1'b0;
    end
  end

  // Pop is limited to the slots actually visible on out_data (bypassed slots count when bypassing).
  always_comb begin
    if (bypass)                        pop_lim = npush;
    else if (count >= CW'(ISSUE_NUM))  pop_lim = PW'(ISSUE_NUM);
    else                               pop_lim = PW'(count);
    pop_eff = (pop_num > pop_lim) ? pop_lim : pop_num;
  end

  // Slot write enables; slots consumed straight off the bypass are never stored.
  always_comb begin
    for (int i = 0; i < ISSUE_NUM; i++) begin
      wr_en[i] = (PW'(i) < npush) && !(bypass && (PW'(i) < pop_eff));
    end
  end

  // Entry storage: slot i lands at tail+i, wrapping naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ISSUE_NUM; i++) begin
      if (wr_en[i] && !rst && !flush) mem[tail + AW'(i)] <= push_data[i];
    end
  end

  // Pointer and occupancy update; flush and reset discard this cycle's push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_eff);
      tail  <= tail + AW'(npush);
      count <= count + CW'(npush) - CW'(pop_eff);
    end
  end

  // Head window in program order; valid is gated by occupancy since storage is never cleared.
  always_comb begin
    for (int i = 0; i < ISSUE_NUM; i++) begin
      out_data[i]       = mem[head + AW'(i)];
      out_data[i].valid = (count > CW'(i));
    end
`ifdef ISSUE_FIFO_BYPASS_EN
    if (bypass) out_data = push_data;
`endif
  end

endmodule
